// File: rtl/qrd_row_buffer.sv
// Ping-pong row buffer after the QRD core: gathers four columns into a 4x4 matrix,
// then replays it row by row over valid/ready. Matrices that find no free bank are dropped.
module qrd_row_buffer #(
    parameter int WIDTH  = 17,
    parameter int DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in0,
    input  logic signed [WIDTH-1:0] in1,
    input  logic signed [WIDTH-1:0] in2,
    input  logic signed [WIDTH-1:0] in3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out0,
    output logic signed [WIDTH-1:0] out1,
    output logic signed [WIDTH-1:0] out2,
    output logic signed [WIDTH-1:0] out3,
    output logic                    out_last,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_cnt
);

    typedef logic [WIDTH-1:0] word_t;

    word_t             mem [2][4][4];
    word_t             in_lane [4];
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic [1:0]        wr_col;
    logic [1:0]        rd_row;
    logic              wr_bank;
    logic              rd_bank;
    logic              drop_mode;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              overflow_q;

    logic rd_hs;
    logic rd_done;
    logic wr_free;
    logic wr_drop;
    logic wr_store;
    logic wr_done;

    always_comb begin
        in_lane[0] = in0;
        in_lane[1] = in1;
        in_lane[2] = in2;
        in_lane[3] = in3;
    end

    // A bank released by the final row handshake this cycle is already free for column 0.
    assign rd_hs    = full[rd_bank] & out_ready;
    assign rd_done  = rd_hs & (rd_row == 2'd3);
    assign wr_free  = ~full[wr_bank] | (rd_done & (rd_bank == wr_bank));
    assign wr_drop  = (wr_col == 2'd0) ? ~wr_free : drop_mode;
    assign wr_store = in_valid & ~wr_drop;
    assign wr_done  = wr_store & (wr_col == 2'd3);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        full_next = full;
        if (rd_done) full_next[rd_bank] = 1'b0;
        if (wr_done) full_next[wr_bank] = 1'b1;
    end

    // NOTE: the storage array is reset too, because the outputs read it directly and must be 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        mem[b][r][c] <= '0;
        end else if (wr_store) begin
            for (int k = 0; k < 4; k++)
                mem[wr_bank][k][wr_col] <= in_lane[k];
        end
    end

    // NOTE: registered state is updated with non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full       <= '0;
            wr_col     <= '0;
            wr_bank    <= 1'b0;
            drop_mode  <= 1'b0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            full <= full_next;
            if (in_valid) begin
                wr_col <= wr_col + 2'd1;
                if (wr_drop) begin
                    if (wr_col == 2'd3) begin
                        drop_mode  <= 1'b0;
                        overflow_q <= 1'b1;
                        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
                    end else begin
                        drop_mode <= 1'b1;
                    end
                end else if (wr_col == 2'd3) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_row  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_hs) begin
            rd_row <= rd_row + 2'd1;
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    assign out_valid = full[rd_bank];
    assign out_last  = full[rd_bank] & (rd_row == 2'd3);
    assign out0      = mem[rd_bank][rd_row][0];
    assign out1      = mem[rd_bank][rd_row][1];
    assign out2      = mem[rd_bank][rd_row][2];
    assign out3      = mem[rd_bank][rd_row][3];
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_qrd_row_buffer.sv
// Directed bench for qrd_row_buffer: single matrix, streaming, overflow, bypass,
// backpressure, extreme values and mid-matrix reset.
module tb_qrd_row_buffer;

    localparam int W  = 17;
    localparam int DW = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic signed [W-1:0] in0, in1, in2, in3;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out0, out1, out2, out3;
    logic                out_last;
    logic                overflow;
    logic [DW-1:0]       drop_cnt;

    qrd_row_buffer #(.WIDTH(W), .DROP_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out_last(out_last), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d0, d1, d2, d3;
        logic         last;
        int           cyc;
    } row_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    row_t         rows[$];
    logic [W-1:0] mat [4][4];

    always @(posedge clk) cyc <= cyc + 1;

    // Rows are recorded mid-cycle when a handshake is about to complete on the next edge.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            rows.push_back('{out0, out1, out2, out3, out_last, cyc});

    function automatic logic [4*W:0] exp_row(input int base, input int r);
        logic [W-1:0] e0, e1, e2, e3;
        e0 = W'(base + 4*r);
        e1 = W'(base + 4*r + 1);
        e2 = W'(base + 4*r + 2);
        e3 = W'(base + 4*r + 3);
        return {e0, e1, e2, e3, (r == 3)};
    endfunction

    function automatic logic [4*W:0] got_row(input row_t x);
        return {x.d0, x.d1, x.d2, x.d3, x.last};
    endfunction

    task automatic set_mat(input int base);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                mat[k][c] = W'(base + 4*k + c);
    endtask

    task automatic send_cols(input int first, input int last, input bit keep);
        for (int c = first; c <= last; c++) begin
            in_valid = 1'b1;
            in0 = mat[0][c]; in1 = mat[1][c]; in2 = mat[2][c]; in3 = mat[3][c];
            @(posedge clk); #1;
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rows.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_last, overflow, drop_cnt, out0, out1, out2, out3} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b last=%b ovf=%b drop=%0d out=%h/%h/%h/%h want all 0",
                     out_valid, out_last, overflow, drop_cnt, out0, out1, out2, out3);
        end
    endtask

    task automatic test_single();
        logic [4*W:0] got;
        do_reset();
        out_ready = 1'b1;
        set_mat(0);
        send_cols(0, 2, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_early_valid: got %b want 0", out_valid);
        end
        send_cols(3, 3, 1'b0);
        for (int r = 0; r < 4; r++) begin
            got = {out0, out1, out2, out3, out_last};
            checks++;
            if (out_valid !== 1'b1 || got !== exp_row(0, r)) begin
                errors++;
                $display("FAIL single_row%0d: got valid=%b row=%h want valid=1 row=%h", r, out_valid, got, exp_row(0, r));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_valid_drop: got %b want 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int m = 0; m < 3; m++) begin
            set_mat(100 * (m + 1));
            send_cols(0, 3, 1'b1);
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (rows.size() != 12) begin
            errors++; $display("FAIL stream_count: got %0d want 12", rows.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (got_row(rows[i]) !== exp_row(100 * (i / 4 + 1), i % 4) || rows[i].cyc != rows[0].cyc + i) begin
                    errors++;
                    $display("FAIL stream_row%0d: got %h at cyc %0d want %h at cyc %0d", i,
                             got_row(rows[i]), rows[i].cyc, exp_row(100 * (i / 4 + 1), i % 4), rows[0].cyc + i);
                end
            end
        end
        checks++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL stream_drops: got drop=%0d ovf=%b want 0 0", drop_cnt, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [4*W:0] held;
        do_reset();
        for (int m = 0; m < 3; m++) begin
            set_mat(16 * m);
            send_cols(0, 3, 1'b0);
        end
        held = {out0, out1, out2, out3, out_last};
        checks++;
        if (drop_cnt !== 8'd1 || overflow !== 1'b1 || out_valid !== 1'b1 || held !== exp_row(0, 0)) begin
            errors++;
            $display("FAIL ovf_state: got drop=%0d ovf=%b valid=%b row=%h want 1 1 1 %h",
                     drop_cnt, overflow, out_valid, held, exp_row(0, 0));
        end
        out_ready = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (rows.size() != 8) begin
            errors++; $display("FAIL ovf_count: got %0d want 8", rows.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_row(rows[i]) !== exp_row(16 * (i / 4), i % 4)) begin
                    errors++;
                    $display("FAIL ovf_row%0d: got %h want %h", i, got_row(rows[i]), exp_row(16 * (i / 4), i % 4));
                end
            end
        end
        rows.delete();
        set_mat(48);
        send_cols(0, 3, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (rows.size() != 4 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ovf_after: got rows=%0d ovf=%b drop=%0d want 4 1 1", rows.size(), overflow, drop_cnt);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_row(rows[i]) !== exp_row(48, i)) begin
                    errors++; $display("FAIL ovf_d_row%0d: got %h want %h", i, got_row(rows[i]), exp_row(48, i));
                end
            end
        end
    endtask

    task automatic test_bypass();
        do_reset();
        set_mat(0);  send_cols(0, 3, 1'b0);
        set_mat(16); send_cols(0, 3, 1'b0);
        // Row-3 handshake of bank 0 lands on the edge that samples column 0 of the next matrix.
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        set_mat(32); send_cols(0, 3, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0 || rows.size() != 12) begin
            errors++;
            $display("FAIL bypass_accept: got drop=%0d ovf=%b rows=%0d want 0 0 12", drop_cnt, overflow, rows.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (got_row(rows[i]) !== exp_row(16 * (i / 4), i % 4)) begin
                    errors++;
                    $display("FAIL bypass_row%0d: got %h want %h", i, got_row(rows[i]), exp_row(16 * (i / 4), i % 4));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit           pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
        int           idx = 0;
        logic [4*W:0] got;
        do_reset();
        set_mat(200);
        send_cols(0, 3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            out_ready = pat[i];
            got = {out0, out1, out2, out3, out_last};
            if (idx < 4) begin
                checks++;
                if (out_valid !== 1'b1 || got !== exp_row(200, idx)) begin
                    errors++;
                    $display("FAIL bp_step%0d: got valid=%b row=%h want valid=1 row=%h", i, out_valid, got, exp_row(200, idx));
                end
            end
            @(posedge clk); #1;
            if (pat[i]) idx++;
        end
        checks++;
        if (rows.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d want 4", rows.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_row(rows[i]) !== exp_row(200, i)) begin
                    errors++; $display("FAIL bp_row%0d: got %h want %h", i, got_row(rows[i]), exp_row(200, i));
                end
            end
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [4*W:0] want;
        lo = 17'h10000;
        hi = 17'h0FFFF;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                mat[k][c] = ((k + c) % 2 == 0) ? lo : hi;
        send_cols(0, 3, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rows.size() != 4) begin
            errors++; $display("FAIL ext_count: got %0d want 4", rows.size());
        end else begin
            for (int r = 0; r < 4; r++) begin
                want = (r % 2 == 0) ? {lo, hi, lo, hi, (r == 3)} : {hi, lo, hi, lo, (r == 3)};
                checks++;
                if (got_row(rows[r]) !== want) begin
                    errors++; $display("FAIL ext_row%0d: got %h want %h", r, got_row(rows[r]), want);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b1;
        set_mat(500);
        send_cols(0, 1, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({out_valid, out_last, overflow, drop_cnt, out0, out1, out2, out3} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got valid=%b out=%h/%h/%h/%h want all 0", out_valid, out0, out1, out2, out3);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rows.delete();
        set_mat(600);
        send_cols(0, 3, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (rows.size() != 4) begin
            errors++; $display("FAIL midrst_count: got %0d want 4", rows.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_row(rows[i]) !== exp_row(600, i)) begin
                    errors++; $display("FAIL midrst_row%0d: got %h want %h", i, got_row(rows[i]), exp_row(600, i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_overflow();
        test_bypass();
        test_backpressure();
        test_extremes();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
